// File: rtl/rst_gen.sv
// Reset conditioner: turns power-on reset and a bouncing pushbutton into clean,
// fixed-width active-high sys_rst pulses for the clock divider and CPU core.
module rst_gen #(
    parameter int unsigned DEB_CYC  = 16,
    parameter int unsigned HOLD_CYC = 8,
    parameter int unsigned CW       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       sys_rst,
    output logic       busy,
    output logic [7:0] rst_cnt
);

    typedef enum logic [2:0] {
        S_POR,
        S_RUN,
        S_DEB,
        S_ASSERT,
        S_REL
    } state_e;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

    logic          sync1_q;
    logic          btn_s_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sys_rst_q, sys_rst_d;
    logic          busy_q, busy_d;
    logic [7:0]    rst_cnt_q, rst_cnt_d;

    // btn is asynchronous to clk; only btn_s_q may be read by the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            btn_s_q <= sync1_q;
        end
    end

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        rst_cnt_d = rst_cnt_q;

        case (state_q)
            S_POR: begin
                if (cnt_q == HOLD_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = '0;
                if (btn_s_q) state_d = S_DEB;
            end
            S_DEB: begin
                if (!btn_s_q) begin
                    state_d = S_RUN;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_ASSERT;
                    if (rst_cnt_q != 8'hFF) rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end
            S_ASSERT: begin
                if (cnt_q == HOLD_LAST) state_d = S_REL;
            end
            S_REL: begin
                if (btn_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_POR;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Outputs are registered from the next state so they change with it.
        sys_rst_d = (state_d == S_POR) || (state_d == S_ASSERT);
        busy_d    = (state_d != S_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_POR;
            cnt_q     <= '0;
            sys_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            rst_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sys_rst_q <= sys_rst_d;
            busy_q    <= busy_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign sys_rst = sys_rst_q;
    assign busy    = busy_q;
    assign rst_cnt = rst_cnt_q;

endmodule

// File: tb/tb_rst_gen.sv
// Directed self-checking bench for rst_gen with DEB_CYC=16, HOLD_CYC=8:
// power-on, clean press, bounce, release bounce, async reset mid-pulse, saturation.
module tb_rst_gen;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       sys_rst;
    logic       busy;
    logic [7:0] rst_cnt;

    int checks   = 0;
    int failures = 0;

    // Pulse monitor: counts completed sys_rst pulses and those not 8 cycles wide.
    logic mon_en   = 1'b0;
    logic mon_prev = 1'b0;
    int   cur_w    = 0;
    int   n_pulses = 0;
    int   bad_w    = 0;
    int   mark;

    rst_gen #(
        .DEB_CYC (16),
        .HOLD_CYC(8),
        .CW      (20)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .sys_rst(sys_rst),
        .busy   (busy),
        .rst_cnt(rst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (!mon_en) begin
            cur_w    = 0;
            mon_prev = sys_rst;
        end else begin
            if (sys_rst) begin
                cur_w++;
            end else if (mon_prev) begin
                n_pulses++;
                if (cur_w != 8) bad_w++;
                cur_w = 0;
            end
            mon_prev = sys_rst;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic press_hold(input int hi, input int lo);
        btn = 1'b1;
        tick(hi);
        btn = 1'b0;
        tick(lo);
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;

        // 1. Power-on
        #2 rst = 1'b0;
        #1;
        check("por_async_sys_rst", int'(sys_rst), 1);
        check("por_async_busy", int'(busy), 1);
        check("por_async_rst_cnt", int'(rst_cnt), 0);
        tick(3);
        check("por_held_sys_rst", int'(sys_rst), 1);
        rst = 1'b1;
        tick(7);
        check("por_edge7_sys_rst", int'(sys_rst), 1);
        check("por_edge7_busy", int'(busy), 1);
        tick(1);
        check("por_edge8_sys_rst", int'(sys_rst), 0);
        check("por_edge8_busy", int'(busy), 0);
        check("por_rst_cnt", int'(rst_cnt), 0);
        mon_en = 1'b1;
        tick(2);

        // 2. Clean press held 100 cycles
        mark = n_pulses;
        btn = 1'b1;
        tick(18);
        check("press_edge17_sys_rst", int'(sys_rst), 0);
        check("press_deb_busy", int'(busy), 1);
        tick(1);
        check("press_edge18_sys_rst", int'(sys_rst), 1);
        check("press_rst_cnt", int'(rst_cnt), 1);
        tick(7);
        check("press_width7_sys_rst", int'(sys_rst), 1);
        tick(1);
        check("press_width8_sys_rst", int'(sys_rst), 0);
        check("press_rel_busy", int'(busy), 1);
        tick(73);
        check("press_held_pulses", n_pulses - mark, 1);
        check("press_held_busy", int'(busy), 1);
        btn = 1'b0;
        tick(17);
        check("release_edge16_busy", int'(busy), 1);
        tick(1);
        check("release_edge17_busy", int'(busy), 0);
        tick(3);

        // 3. Bounce with high runs of 1..10 cycles, then boundary runs
        mark = n_pulses;
        for (int i = 0; i < 16; i++) begin
            press_hold(1 + (i % 10), 3);
        end
        tick(30);
        check("bounce_pulses", n_pulses - mark, 0);
        check("bounce_rst_cnt", int'(rst_cnt), 1);
        check("bounce_busy", int'(busy), 0);
        press_hold(16, 40);
        check("run16_pulses", n_pulses - mark, 0);
        check("run16_rst_cnt", int'(rst_cnt), 1);
        press_hold(17, 60);
        check("run17_pulses", n_pulses - mark, 1);
        check("run17_rst_cnt", int'(rst_cnt), 2);
        check("run17_busy", int'(busy), 0);

        // 4. Release bounce during REL, then a second press
        mark = n_pulses;
        press_hold(40, 5);
        press_hold(5, 5);
        check("relbounce_busy", int'(busy), 1);
        press_hold(5, 5);
        check("relbounce_pulses_mid", n_pulses - mark, 1);
        tick(30);
        check("relbounce_settled_busy", int'(busy), 0);
        press_hold(40, 30);
        check("relbounce_pulses", n_pulses - mark, 2);
        check("relbounce_rst_cnt", int'(rst_cnt), 4);

        // 5. Async reset on the 4th cycle of a pulse
        mon_en = 1'b0;
        btn = 1'b1;
        tick(19);
        check("midpulse_first_cycle", int'(sys_rst), 1);
        tick(3);
        check("midpulse_rst_cnt_before", int'(rst_cnt), 5);
        rst = 1'b0;
        btn = 1'b0;
        #1;
        check("midpulse_async_rst_cnt", int'(rst_cnt), 0);
        check("midpulse_async_sys_rst", int'(sys_rst), 1);
        check("midpulse_async_busy", int'(busy), 1);
        tick(3);
        rst = 1'b1;
        tick(7);
        check("midpulse_por7_sys_rst", int'(sys_rst), 1);
        tick(1);
        check("midpulse_por8_sys_rst", int'(sys_rst), 0);
        check("midpulse_por8_busy", int'(busy), 0);
        mon_en = 1'b1;
        tick(2);

        // 6. Saturation over 260 presses
        mark = n_pulses;
        bad_w = 0;
        for (int i = 0; i < 260; i++) begin
            press_hold(30, 25);
            if (i == 253) check("sat_254", int'(rst_cnt), 254);
            if (i == 254) check("sat_255", int'(rst_cnt), 255);
        end
        check("sat_final_rst_cnt", int'(rst_cnt), 255);
        check("sat_pulses", n_pulses - mark, 260);
        check("sat_bad_widths", bad_w, 0);
        check("sat_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
